// File: rtl/parser_pkg.sv
// Shared parser types and constants, plus the head generator's state encoding and register indices.
package parser_pkg;

  localparam int unsigned HEAD_WIDTH        = 64;
  localparam int unsigned META_WIDTH        = 32;
  localparam int unsigned TAG_WIDTH         = 3;
  localparam int unsigned TAG_START_BIT     = 0;
  localparam int unsigned TAG_VALID_BIT     = 1;
  localparam int unsigned TAG_TAIL_BIT      = 2;
  localparam int unsigned TYPE_NUM          = 2;
  localparam int unsigned KEY_FILED_NUM     = 2;
  localparam int unsigned TYPE_OFFSET_WIDTH = 8;
  localparam int unsigned KEY_OFFSET_WIDTH  = 8;
  localparam int unsigned HEAD_SHIFT_WIDTH  = 8;
  localparam int unsigned META_SHIFT_WIDTH  = 8;

  localparam int unsigned TYPE_IDX_W = (TYPE_NUM > 1) ? $clog2(TYPE_NUM) : 1;
  localparam int unsigned KEY_IDX_W  = (KEY_FILED_NUM > 1) ? $clog2(KEY_FILED_NUM) : 1;

  typedef struct packed {
    logic [TAG_WIDTH+HEAD_WIDTH-1:0]                  head;
    logic [TAG_WIDTH+META_WIDTH-1:0]                  meta;
    logic [TYPE_NUM-1:0][TYPE_OFFSET_WIDTH-1:0]       type_offset;
    logic [KEY_FILED_NUM-1:0]                         key_offset_v;
    logic [KEY_FILED_NUM-1:0][KEY_OFFSET_WIDTH-1:0]   key_offset;
    logic [HEAD_SHIFT_WIDTH-1:0]                      headShift;
    logic [META_SHIFT_WIDTH-1:0]                      metaShift;
  } layer_info_t;

  // Software-visible seed configuration (live and per-packet shadow copies).
  typedef struct packed {
    logic [TYPE_NUM-1:0][TYPE_OFFSET_WIDTH-1:0]       type_offset;
    logic [KEY_FILED_NUM-1:0]                         key_offset_v;
    logic [KEY_FILED_NUM-1:0][KEY_OFFSET_WIDTH-1:0]   key_offset;
    logic [HEAD_SHIFT_WIDTH-1:0]                      head_shift;
    logic [META_SHIFT_WIDTH-1:0]                      meta_shift;
  } head_gen_cfg_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HEAD = 2'd1,
    SKIP = 2'd2,
    GAP  = 2'd3
  } head_gen_state_e;

  localparam logic [7:0] HG_ADDR_TYPE_OFF   = 8'd0;
  localparam logic [7:0] HG_ADDR_KEY_OFF    = 8'd16;
  localparam logic [7:0] HG_ADDR_HEAD_SHIFT = 8'd32;
  localparam logic [7:0] HG_ADDR_META_SHIFT = 8'd33;
  localparam logic [7:0] HG_ADDR_STAT       = 8'd48;

  function automatic logic [TAG_WIDTH-1:0] make_tag(input logic start, input logic valid,
                                                     input logic tail);
    logic [TAG_WIDTH-1:0] t;
    t = '0;
    t[TAG_START_BIT] = start;
    t[TAG_VALID_BIT] = valid;
    t[TAG_TAIL_BIT]  = tail;
    return t;
  endfunction

endpackage

// File: rtl/parser_head_gen_conf.sv
// Head generator register file: live config, per-packet shadow copy, read mux and
// optional statistics counters (PARSER_HEAD_STAT_EN).
module head_gen_conf
  import parser_pkg::*;
(
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_conf_wren,
  input  logic          i_conf_rden,
  input  logic [31:0]   i_conf_addr,
  input  logic [31:0]   i_conf_wdata,
  input  logic          i_shadow_load,
  input  logic          i_pkt_inc,
  input  logic          i_err_inc,
  input  logic          i_trunc_inc,
  output logic          o_conf_rdata_valid,
  output logic [31:0]   o_conf_rdata,
  output head_gen_cfg_t o_cfg,
  output head_gen_cfg_t o_shadow
);

  logic [7:0]  addr;
  logic [31:0] rdata_c;
  logic        unused_conf;

  assign addr        = i_conf_addr[7:0];
  assign unused_conf = ^{i_conf_addr[31:8], i_conf_wdata[30:TYPE_OFFSET_WIDTH]};

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_cfg <= '0;
    end else if (i_conf_wren) begin
      for (int i = 0; i < TYPE_NUM; i++) begin
        if (addr == HG_ADDR_TYPE_OFF + 8'(i))
          o_cfg.type_offset[TYPE_IDX_W'(i)] <= i_conf_wdata[TYPE_OFFSET_WIDTH-1:0];
      end
      for (int j = 0; j < KEY_FILED_NUM; j++) begin
        if (addr == HG_ADDR_KEY_OFF + 8'(j)) begin
          o_cfg.key_offset_v[KEY_IDX_W'(j)] <= i_conf_wdata[31];
          o_cfg.key_offset[KEY_IDX_W'(j)]   <= i_conf_wdata[KEY_OFFSET_WIDTH-1:0];
        end
      end
      if (addr == HG_ADDR_HEAD_SHIFT) o_cfg.head_shift <= i_conf_wdata[HEAD_SHIFT_WIDTH-1:0];
      if (addr == HG_ADDR_META_SHIFT) o_cfg.meta_shift <= i_conf_wdata[META_SHIFT_WIDTH-1:0];
    end
  end

  // Shadow freezes the seed for the packet whose sop is being accepted.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_shadow <= '0;
    end else if (i_shadow_load) begin
      o_shadow <= o_cfg;
    end
  end

`ifdef PARSER_HEAD_STAT_EN
  logic [31:0] pkt_cnt;
  logic [31:0] err_cnt;
  logic [31:0] trunc_cnt;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      pkt_cnt   <= '0;
      err_cnt   <= '0;
      trunc_cnt <= '0;
    end else begin
      if (i_pkt_inc)   pkt_cnt   <= pkt_cnt + 32'd1;
      if (i_err_inc)   err_cnt   <= err_cnt + 32'd1;
      if (i_trunc_inc) trunc_cnt <= trunc_cnt + 32'd1;
    end
  end
`else
  logic unused_stat;
  assign unused_stat = ^{i_pkt_inc, i_err_inc, i_trunc_inc};
`endif

  always_comb begin
    rdata_c = '0;
    for (int i = 0; i < TYPE_NUM; i++) begin
      if (addr == HG_ADDR_TYPE_OFF + 8'(i))
        rdata_c = 32'(o_cfg.type_offset[TYPE_IDX_W'(i)]);
    end
    for (int j = 0; j < KEY_FILED_NUM; j++) begin
      if (addr == HG_ADDR_KEY_OFF + 8'(j)) begin
        rdata_c     = 32'(o_cfg.key_offset[KEY_IDX_W'(j)]);
        rdata_c[31] = o_cfg.key_offset_v[KEY_IDX_W'(j)];
      end
    end
    if (addr == HG_ADDR_HEAD_SHIFT) rdata_c = 32'(o_cfg.head_shift);
    if (addr == HG_ADDR_META_SHIFT) rdata_c = 32'(o_cfg.meta_shift);
`ifdef PARSER_HEAD_STAT_EN
    if (addr == HG_ADDR_STAT)         rdata_c = pkt_cnt;
    if (addr == HG_ADDR_STAT + 8'd1)  rdata_c = err_cnt;
    if (addr == HG_ADDR_STAT + 8'd2)  rdata_c = trunc_cnt;
`endif
  end

  // Read data is sampled before this cycle's write lands, so a same-cycle write returns the old value.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_conf_rdata_valid <= 1'b0;
      o_conf_rdata       <= '0;
    end else begin
      o_conf_rdata_valid <= i_conf_rden;
      o_conf_rdata       <= i_conf_rden ? rdata_c : 32'd0;
    end
  end

endmodule

// File: rtl/parser_head_gen.sv
// Parser front end: frames raw beats into tagged head slices and seeds layer 0.
// Statistics counters are built only with PARSER_HEAD_STAT_EN defined.
module parser_head_gen
  import parser_pkg::*;
#(
  parameter int unsigned MAX_HEAD_BEATS = 2,
  parameter int unsigned MIN_GAP        = 2
)(
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [HEAD_WIDTH-1:0] i_data,
  input  logic                  i_valid,
  input  logic                  i_sop,
  input  logic                  i_eop,
  output logic                  o_ready,
  input  logic                  i_conf_wren,
  input  logic                  i_conf_rden,
  input  logic [31:0]           i_conf_addr,
  input  logic [31:0]           i_conf_wdata,
  output logic                  o_conf_rdata_valid,
  output logic [31:0]           o_conf_rdata,
  output layer_info_t           o_layer_info
);

  localparam int unsigned BEAT_CNT_W = $clog2(MAX_HEAD_BEATS + 1);
  localparam int unsigned GAP_CNT_W  = (MIN_GAP > 0) ? $clog2(MIN_GAP + 1) : 1;
  localparam logic [BEAT_CNT_W-1:0] BEAT_LAST = BEAT_CNT_W'(MAX_HEAD_BEATS);
  localparam logic [GAP_CNT_W-1:0]  GAP_LAST  = GAP_CNT_W'(MIN_GAP);

  head_gen_state_e       state;
  logic [BEAT_CNT_W-1:0] beat_cnt;
  logic [BEAT_CNT_W-1:0] beat_num_c;
  logic [GAP_CNT_W-1:0]  gap_cnt;
  logic                  acc_c;
  logic                  sop_acc_c;
  logic                  emit_c;
  logic                  tail_c;
  logic                  trunc_c;
  logic                  pkt_end_c;
  logic                  err_c;
  logic [TAG_WIDTH-1:0]  tag_c;
  head_gen_cfg_t         cfg;
  head_gen_cfg_t         shadow;
  head_gen_cfg_t         seed_c;

  head_gen_conf u_conf (
    .i_clk              (i_clk),
    .i_rst              (i_rst),
    .i_conf_wren        (i_conf_wren),
    .i_conf_rden        (i_conf_rden),
    .i_conf_addr        (i_conf_addr),
    .i_conf_wdata       (i_conf_wdata),
    .i_shadow_load      (sop_acc_c),
    .i_pkt_inc          (sop_acc_c),
    .i_err_inc          (err_c),
    .i_trunc_inc        (trunc_c),
    .o_conf_rdata_valid (o_conf_rdata_valid),
    .o_conf_rdata       (o_conf_rdata),
    .o_cfg              (cfg),
    .o_shadow           (shadow)
  );

  // Beat classification; a sop always (re)starts framing, so its seed comes from the live config.
  always_comb begin
    acc_c      = i_valid & o_ready;
    sop_acc_c  = acc_c & i_sop;
    emit_c     = 1'b0;
    beat_num_c = beat_cnt;
    if (sop_acc_c) begin
      emit_c     = 1'b1;
      beat_num_c = BEAT_CNT_W'(1);
    end else if (acc_c && (state == HEAD)) begin
      emit_c     = 1'b1;
      beat_num_c = beat_cnt + BEAT_CNT_W'(1);
    end
    tail_c    = emit_c & (i_eop | (beat_num_c == BEAT_LAST));
    trunc_c   = emit_c & ~i_eop & (beat_num_c == BEAT_LAST);
    pkt_end_c = acc_c & i_eop & (sop_acc_c | (state == HEAD) | (state == SKIP));
    err_c     = acc_c & ((state == IDLE) ? ~i_sop : i_sop);
    tag_c     = make_tag(sop_acc_c, emit_c, tail_c);
    seed_c    = sop_acc_c ? cfg : shadow;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state        <= IDLE;
      beat_cnt     <= '0;
      gap_cnt      <= '0;
      o_ready      <= 1'b0;
      o_layer_info <= '0;
    end else begin
      if (pkt_end_c) begin
        if (MIN_GAP > 0) begin
          state   <= GAP;
          gap_cnt <= GAP_CNT_W'(1);
          o_ready <= 1'b0;
        end else begin
          state   <= IDLE;
          o_ready <= 1'b1;
        end
      end else if (trunc_c) begin
        state   <= SKIP;
        o_ready <= 1'b1;
      end else if (sop_acc_c) begin
        state   <= HEAD;
        o_ready <= 1'b1;
      end else if (state == GAP) begin
        if (gap_cnt >= GAP_LAST) begin
          state   <= IDLE;
          o_ready <= 1'b1;
        end else begin
          gap_cnt <= gap_cnt + GAP_CNT_W'(1);
          o_ready <= 1'b0;
        end
      end else begin
        o_ready <= 1'b1;
      end

      // In SKIP the count stays parked at MAX_HEAD_BEATS.
      if (emit_c) beat_cnt <= beat_num_c;

      o_layer_info.head         <= {tag_c, emit_c ? i_data : HEAD_WIDTH'(0)};
      o_layer_info.meta         <= {tag_c, META_WIDTH'(0)};
      o_layer_info.type_offset  <= seed_c.type_offset;
      o_layer_info.key_offset_v <= seed_c.key_offset_v;
      o_layer_info.key_offset   <= seed_c.key_offset;
      o_layer_info.headShift    <= seed_c.head_shift;
      o_layer_info.metaShift    <= seed_c.meta_shift;
    end
  end

endmodule
